// File: rtl/seq_multiplier_hs.sv
// Radix-2 shift-add unsigned multiplier with valid/ready handshakes on both the
// operand and the result side, plus a count of completed result handshakes.
module seq_multiplier_hs #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic [CNT_W-1:0]     op_count
);

    localparam int PW = 2 * WIDTH;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // cnt runs 0..WIDTH; the extra step at WIDTH transfers acc into P.
    localparam logic [BW-1:0] CNT_LAST = BW'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc;
    logic [BW-1:0]    cnt;
    logic [PW-1:0]    addend;

    always_comb begin
        addend = '0;
        if (mplier[0]) begin
            addend = {{WIDTH{1'b0}}, mcand} << cnt;
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            P        <= '0;
            op_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= '0;
                        // A zero operand skips the shift-add loop entirely.
                        if (A == '0 || B == '0) begin
                            P     <= '0;
                            state <= S_DONE;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (cnt == CNT_LAST) begin
                        P     <= acc;
                        state <= S_DONE;
                    end else begin
                        acc    <= acc + addend;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + BW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        op_count <= op_count + CNT_W'(1);
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier_hs.sv
// Bench for seq_multiplier_hs: a WIDTH=8/CNT_W=4 instance and a WIDTH=2 instance,
// checked against plain-arithmetic products, latencies and handshake counts.
module tb_seq_multiplier_hs;

    logic clk = 1'b0;
    logic rst_n;

    logic        iv8, ir8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic [3:0]  oc8;

    logic        iv2, ir2, ov2, or2;
    logic [1:0]  a2, b2;
    logic [3:0]  p2;
    logic [15:0] oc2;

    int n_assert = 0;
    int n_fail   = 0;
    int cnt8     = 0;
    int cnt2     = 0;

    always #5 clk = ~clk;

    seq_multiplier_hs #(.WIDTH(8), .CNT_W(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .out_valid(ov8), .out_ready(or8), .P(p8), .op_count(oc8)
    );

    seq_multiplier_hs #(.WIDTH(2), .CNT_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .A(a2), .B(b2),
        .out_valid(ov2), .out_ready(or2), .P(p2), .op_count(oc2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Latency is counted in edges after the accept edge up to the edge that
    // registers DONE: WIDTH+1 for nonzero operands, 0 for the zero shortcut.
    task automatic op8(input int a, input int b, input int hold);
        int exp_p, exp_lat, lat, t;
        exp_p   = a * b;
        exp_lat = (a == 0 || b == 0) ? 0 : 9;
        t = 0;
        while (ir8 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("w8_in_ready_idle", 32'(ir8), 1);
        a8 = 8'(a); b8 = 8'(b); iv8 = 1'b1; or8 = 1'bx;
        @(posedge clk); #1;
        iv8 = 1'b0; or8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            check("w8_in_ready_busy", 32'(ir8), 0);
            @(posedge clk); #1;
            lat++;
            a8 = 8'($urandom); b8 = 8'($urandom);
        end
        check("w8_latency", lat, exp_lat);
        check("w8_product", 32'(p8), exp_p);
        check("w8_in_ready_done", 32'(ir8), 0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("w8_bp_valid", 32'(ov8), 1);
            check("w8_bp_product", 32'(p8), exp_p);
            check("w8_bp_in_ready", 32'(ir8), 0);
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        or8 = 1'b0;
        cnt8 = (cnt8 + 1) % 16;
        check("w8_hs_out_valid", 32'(ov8), 0);
        check("w8_hs_in_ready", 32'(ir8), 1);
        check("w8_op_count", 32'(oc8), cnt8);
        check("w8_p_kept", 32'(p8), exp_p);
    endtask

    task automatic op2(input int a, input int b);
        int exp_p, exp_lat, lat, t;
        exp_p   = a * b;
        exp_lat = (a == 0 || b == 0) ? 0 : 3;
        t = 0;
        while (ir2 !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
        check("w2_in_ready_idle", 32'(ir2), 1);
        a2 = 2'(a); b2 = 2'(b); iv2 = 1'b1; or2 = 1'bx;
        @(posedge clk); #1;
        iv2 = 1'b0; or2 = 1'b1; a2 = 2'($urandom); b2 = 2'($urandom);
        lat = 0;
        while (ov2 !== 1'b1 && lat < 40) begin
            check("w2_in_ready_busy", 32'(ir2), 0);
            @(posedge clk); #1;
            lat++;
        end
        check("w2_latency", lat, exp_lat);
        check("w2_product", 32'(p2), exp_p);
        @(posedge clk); #1;
        or2 = 1'b0;
        cnt2 = (cnt2 + 1) % 65536;
        check("w2_hs_out_valid", 32'(ov2), 0);
        check("w2_op_count", 32'(oc2), cnt2);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt8 = 0;
        cnt2 = 0;
    endtask

    int pa2[8] = '{3, 1, 1, 1, 2, 3, 2, 2};
    int pb2[8] = '{3, 2, 3, 1, 3, 1, 2, 1};

    initial begin
        int a, b;
        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(ir8), 1);
        check("rst_out_valid", 32'(ov8), 0);
        check("rst_p", 32'(p8), 0);
        check("rst_op_count", 32'(oc8), 0);
        check("rst_w2_in_ready", 32'(ir2), 1);
        check("rst_w2_p", 32'(p2), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) op2(pa2[i], pb2[i]);
        check("w2_final_count", 32'(oc2), 8);

        op8(255, 255, 0);
        op8(128, 2, 0);
        op8(1, 255, 0);
        op8(0, 200, 0);
        op8(37, 0, 0);
        op8(13, 11, 20);

        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            op8(a, b, int'($urandom_range(0, 3)));
        end

        // Abort an operation four cycles into BUSY.
        a8 = 8'd200; b8 = 8'd100; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", 32'(ov8), 0);
        do_reset();
        check("mid_rst_out_valid", 32'(ov8), 0);
        check("mid_rst_p", 32'(p8), 0);
        check("mid_rst_in_ready", 32'(ir8), 1);
        check("mid_rst_op_count", 32'(oc8), 0);
        op8(5, 6, 0);

        do_reset();
        for (int i = 0; i < 15; i++) op8((i % 2) * 9, ((i + 1) % 2) * 77, 0);
        check("wrap_15", 32'(oc8), 15);
        op8(0, 0, 0);
        check("wrap_0", 32'(oc8), 0);
        op8(0, 5, 0);
        check("wrap_1", 32'(oc8), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
